iq_frame_sender: RTL and testbench
==================================

# iq_frame_sender

Sample-stream transmitter that drives the strobe-based complex energy accumulator `square_adder`. It buffers incoming 8-bit offset-binary I/Q samples in a small FIFO. On `start` it presents `FRAME_LEN` samples to the accumulator, one per `acc_ready` pulse, then raises `acc_done` and waits for `acc_complete`. It then captures the 30-bit frame energy and reports it to the downstream detector with a one-cycle valid pulse.

## Interface
- `FRAME_LEN`, 64: samples per frame, 1..1024.
- `FIFO_DEPTH`, 16: input FIFO depth, power of two, 4..256.
- `GAP`, 1: low cycles of `acc_ready` after each pulse, ≥1.
- `CMP_TIMEOUT`, 255: cycles allowed for `acc_complete` after `acc_done` rises, ≥4.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: input sample valid.
- `in_real` in 8: real part, offset binary, passed through unchanged.
- `in_imag` in 8: imaginary part, offset binary, passed through unchanged.
- `in_ready` out 1: FIFO can accept a sample; a push occurs on `in_valid & in_ready`.
- `start` in 1: one-cycle request to send one frame.
- `acc_real` out 8, `acc_imag` out 8: sample presented to the accumulator.
- `acc_ready` out 1: sample strobe; the accumulator samples on its rising edge.
- `acc_done` out 1: frame-end strobe; held high until completion or timeout.
- `acc_complete` in 1: accumulator result-ready level; asynchronous to `clk`.
- `acc_energy` in 30: accumulator total, signed; stable while `acc_complete` is high.
- `energy` out 30: captured frame energy, signed.
- `energy_valid` out 1: one-cycle pulse when `energy` updates.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `timeout_err` out 1: sticky; cleared by the next accepted `start`.

## Operation
- FIFO:
  - `in_ready` = !full & !rst.
  - A push and a pop in the same cycle are both honoured.
  - A push while full cannot occur, because `in_ready` is low.
- FSM states: IDLE, FETCH, STROBE, GAP, DONE, REPORT.
- IDLE
  - `start` → clear sample counter and `timeout_err`; go to FETCH.
  - `start` in any other state is ignored.
- FETCH
  - FIFO non-empty → pop; register the sample onto `acc_real`/`acc_imag`; go to STROBE.
  - FIFO empty → stay in FETCH (underrun stall). `acc_ready` stays low and `acc_real`/`acc_imag` hold.
- STROBE
  - `acc_ready` = 1 for exactly one cycle; increment the counter; go to GAP.
- GAP
  - `acc_ready` = 0 for `GAP` cycles.
  - Then: counter == `FRAME_LEN` → DONE; otherwise → FETCH.
  - `acc_real`/`acc_imag` stay stable from FETCH exit through the end of GAP.
- DONE
  - `acc_done` = 1; `acc_ready` stays 0.
  - `acc_complete` passes through a 2-FF synchronizer. When the synchronized value is 1, capture `acc_energy` into `energy` and go to REPORT.
  - If the timeout counter reaches `CMP_TIMEOUT` first: set `timeout_err`, drop `acc_done`, go to IDLE. `energy` is unchanged and `energy_valid` is not pulsed.
- REPORT
  - `energy_valid` = 1 for one cycle; `acc_done` = 0; go to IDLE.
- `acc_ready` and `acc_done` are registered outputs and are glitch-free. They are never high together.

## Timing
- Reset (async, takes effect immediately): state IDLE, FIFO empty, and `acc_real`, `acc_imag`, `acc_ready`, `acc_done`, `energy`, `energy_valid`, `busy`, `timeout_err` all 0. `in_ready` is 0 while `rst` is high and 1 from the first cycle after release.
- Reset mid-frame: the strobes drop at once and buffered samples are discarded. No `energy_valid` follows.
- With the FIFO never empty:
  - `start` sampled at edge k → FETCH at k+1, first `acc_ready` high during cycle k+2.
  - Pulse period is `GAP`+2 cycles.
  - `acc_done` rises `FRAME_LEN`·(`GAP`+2)+1 cycles after `start`.
- `acc_complete` rising → `energy` loaded 3 cycles later; `energy_valid` high in the cycle after the load.
- Underrun stretches only FETCH; pulse width and `GAP` are unaffected.
- `FRAME_LEN`=1: one pulse, then DONE.

## Test plan
- Sustained frame: `FRAME_LEN`=4, `GAP`=1, behavioral accumulator model; push 4×(0xFF,0x00), then `start`.
  - Exactly 4 `acc_ready` pulses, period 3 cycles, then `acc_done`.
  - `energy`=520200 with a single `energy_valid` pulse.
- Underrun: push 2 samples, `start`, push 2 more 10 cycles later.
  - FSM stalls in FETCH; `acc_ready` stays low during the stall; 4 pulses total.
  - `energy` matches the model sum.
- FIFO full: `FIFO_DEPTH`=4, push 6 back-to-back without `start`.
  - `in_ready` goes low after 4 pushes; only the first 4 samples are sent after `start`.
- Timeout: model never asserts `acc_complete`.
  - `acc_done` drops after 255 cycles, `timeout_err`=1, no `energy_valid`.
  - Next `start` clears `timeout_err`.
- Reset mid-frame: assert `rst` during the 2nd GAP.
  - `acc_ready`/`acc_done` are 0 in the same cycle and the FIFO is empty.
  - A new frame after release reports the correct energy.
- `start` while busy: a second `start` during STROBE is ignored; exactly one `energy_valid` results.

Source files
------------

// File: rtl/iq_frame_sender.sv
// Buffers offset-binary I/Q samples in a small FIFO and strobes one frame into a
// square_adder accumulator, then captures and reports the resulting frame energy.
module iq_frame_sender #(
    parameter int FRAME_LEN   = 64,
    parameter int FIFO_DEPTH  = 16,
    parameter int GAP         = 1,
    parameter int CMP_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_real,
    input  logic [7:0]  in_imag,
    output logic        in_ready,
    input  logic        start,
    output logic [7:0]  acc_real,
    output logic [7:0]  acc_imag,
    output logic        acc_ready,
    output logic        acc_done,
    input  logic        acc_complete,
    input  logic [29:0] acc_energy,
    output logic [29:0] energy,
    output logic        energy_valid,
    output logic        busy,
    output logic        timeout_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FRAME_LEN + 1);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int TW = $clog2(CMP_TIMEOUT);

    localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_LEN);
    localparam logic [GW-1:0] GAP_LAST   = GW'(GAP - 1);
    localparam logic [TW-1:0] TO_LAST    = TW'(CMP_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_STROBE,
        S_GAP,
        S_DONE,
        S_REPORT
    } state_t;

    state_t      state_q, state_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [1:0]  sync_q, sync_d;
    logic [7:0]  acc_real_q, acc_real_d, acc_imag_q, acc_imag_d;
    logic        acc_ready_q, acc_ready_d, acc_done_q, acc_done_d;
    logic [29:0] energy_q, energy_d;
    logic        energy_valid_q, energy_valid_d;
    logic        busy_q, busy_d, timeout_err_q, timeout_err_d;

    logic [15:0] mem [FIFO_DEPTH];
    logic        empty, full, push, pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign in_ready = !full && !rst;
    assign push     = in_valid && in_ready;
    assign pop      = (state_q == S_FETCH) && !empty;

    // NOTE: sample storage has no reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q[AW-1:0]] <= {in_real, in_imag};
        end
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d        = state_q;
        wr_ptr_d       = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d       = rd_ptr_q + {{AW{1'b0}}, pop};
        cnt_d          = cnt_q;
        gap_cnt_d      = gap_cnt_q;
        to_cnt_d       = to_cnt_q;
        sync_d         = {sync_q[0], acc_complete};
        acc_real_d     = acc_real_q;
        acc_imag_d     = acc_imag_q;
        acc_ready_d    = 1'b0;
        acc_done_d     = acc_done_q;
        energy_d       = energy_q;
        energy_valid_d = 1'b0;
        timeout_err_d  = timeout_err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d         = '0;
                    timeout_err_d = 1'b0;
                    state_d       = S_FETCH;
                end
            end
            S_FETCH: begin
                if (!empty) begin
                    {acc_real_d, acc_imag_d} = mem[rd_ptr_q[AW-1:0]];
                    acc_ready_d = 1'b1;
                    state_d     = S_STROBE;
                end
            end
            S_STROBE: begin
                cnt_d     = cnt_q + CW'(1);
                gap_cnt_d = '0;
                state_d   = S_GAP;
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    if (cnt_q == FRAME_LAST) begin
                        acc_done_d = 1'b1;
                        to_cnt_d   = '0;
                        state_d    = S_DONE;
                    end else begin
                        state_d = S_FETCH;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            S_DONE: begin
                // A completion seen on the last allowed cycle still wins over the timeout.
                if (sync_q[1]) begin
                    energy_d   = acc_energy;
                    acc_done_d = 1'b0;
                    state_d    = S_REPORT;
                end else if (to_cnt_q == TO_LAST) begin
                    timeout_err_d = 1'b1;
                    acc_done_d    = 1'b0;
                    state_d       = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
            end
            S_REPORT: begin
                energy_valid_d = 1'b1;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            cnt_q          <= '0;
            gap_cnt_q      <= '0;
            to_cnt_q       <= '0;
            sync_q         <= '0;
            acc_real_q     <= '0;
            acc_imag_q     <= '0;
            acc_ready_q    <= 1'b0;
            acc_done_q     <= 1'b0;
            energy_q       <= '0;
            energy_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            cnt_q          <= cnt_d;
            gap_cnt_q      <= gap_cnt_d;
            to_cnt_q       <= to_cnt_d;
            sync_q         <= sync_d;
            acc_real_q     <= acc_real_d;
            acc_imag_q     <= acc_imag_d;
            acc_ready_q    <= acc_ready_d;
            acc_done_q     <= acc_done_d;
            energy_q       <= energy_d;
            energy_valid_q <= energy_valid_d;
            busy_q         <= busy_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

    assign acc_real     = acc_real_q;
    assign acc_imag     = acc_imag_q;
    assign acc_ready    = acc_ready_q;
    assign acc_done     = acc_done_q;
    assign energy       = energy_q;
    assign energy_valid = energy_valid_q;
    assign busy         = busy_q;
    assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_iq_frame_sender.sv
// Directed bench for iq_frame_sender with a behavioural square_adder model
// (each component mapped to the odd integer 2*x-255 before squaring).
module tb_iq_frame_sender;

    localparam int FRAME_LEN   = 4;
    localparam int FIFO_DEPTH  = 4;
    localparam int GAP         = 1;
    localparam int CMP_TIMEOUT = 255;
    localparam int DONE_REL    = FRAME_LEN * (GAP + 2) + 1;

    logic        clk, rst, in_valid, in_ready, start;
    logic [7:0]  in_real, in_imag, acc_real, acc_imag;
    logic        acc_ready, acc_done, acc_complete;
    logic [29:0] acc_energy, energy;
    logic        energy_valid, busy, timeout_err;

    int n_tests = 0;
    int n_fail  = 0;
    int model_sum;
    int done_hi;
    logic model_block = 1'b0;

    iq_frame_sender #(
        .FRAME_LEN(FRAME_LEN), .FIFO_DEPTH(FIFO_DEPTH), .GAP(GAP), .CMP_TIMEOUT(CMP_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_real(in_real), .in_imag(in_imag),
        .in_ready(in_ready), .start(start), .acc_real(acc_real), .acc_imag(acc_imag),
        .acc_ready(acc_ready), .acc_done(acc_done), .acc_complete(acc_complete),
        .acc_energy(acc_energy), .energy(energy), .energy_valid(energy_valid),
        .busy(busy), .timeout_err(timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int sq(input logic [7:0] v);
        int t;
        t = 2 * int'(v) - 255;
        return t * t;
    endfunction

    // Accumulator model: sums on each strobe, answers acc_done after 3 cycles.
    initial begin
        model_sum = 0; done_hi = 0; acc_complete = 1'b0; acc_energy = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                model_sum = 0; done_hi = 0; acc_complete = 1'b0;
            end else begin
                if (start && !busy) model_sum = 0;
                if (acc_ready) model_sum += sq(acc_real) + sq(acc_imag);
                if (acc_done) begin
                    done_hi++;
                    if (done_hi >= 3 && !model_block) begin
                        acc_complete = 1'b1;
                        acc_energy   = 30'(model_sum);
                    end
                end else begin
                    done_hi = 0;
                    acc_complete = 1'b0;
                end
            end
        end
    end

    task automatic push(input logic [7:0] r, input logic [7:0] i);
        @(posedge clk); #1 in_valid = 1'b1; in_real = r; in_imag = i;
        @(posedge clk); #1 in_valid = 1'b0;
    endtask

    task automatic push_n(input int n, input logic [7:0] r, input logic [7:0] i);
        for (int k = 0; k < n; k++) push(r, i);
    endtask

    // Issues start, then observes ncyc cycles; cycle n is the n-th after the start edge.
    task automatic run_frame(input int ncyc, output int n_p, output int first_p,
                             output int min_gap, output int max_gap, output int max_w,
                             output int done_rise, output int done_len, output int n_ev,
                             output int overlap, output logic te_early);
        int last_p, w;
        n_p = 0; first_p = -1; min_gap = 1000; max_gap = 0; max_w = 0;
        done_rise = -1; done_len = 0; n_ev = 0; overlap = 0; te_early = 1'bx;
        last_p = -1; w = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int n = 1; n <= ncyc; n++) begin
            @(negedge clk);
            if (n == 2) te_early = timeout_err;
            if (acc_ready) begin
                w++;
                if (w > max_w) max_w = w;
                if (w == 1) begin
                    if (n_p == 0) first_p = n;
                    else begin
                        if (n - last_p < min_gap) min_gap = n - last_p;
                        if (n - last_p > max_gap) max_gap = n - last_p;
                    end
                    last_p = n;
                    n_p++;
                end
            end else begin
                w = 0;
            end
            if (acc_done) begin
                if (done_len == 0) done_rise = n;
                done_len++;
            end
            if (acc_ready && acc_done) overlap++;
            if (energy_valid) n_ev++;
        end
    endtask

    task automatic test_reset();
        #12;
        n_tests++;
        if (in_ready !== 1'b0 || acc_ready !== 1'b0 || acc_done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: in_ready=%b acc_ready=%b acc_done=%b busy=%b, expected all 0",
                     in_ready, acc_ready, acc_done, busy);
        end
        n_tests++;
        if (energy !== 30'd0 || energy_valid !== 1'b0 || timeout_err !== 1'b0 ||
            acc_real !== 8'd0 || acc_imag !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_data: energy=%0d ev=%b te=%b real=%0d imag=%0d, expected all 0",
                     energy, energy_valid, timeout_err, acc_real, acc_imag);
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_in_ready: got %b, expected 1", in_ready);
        end
    endtask

    task automatic test_sustained();
        int n_p, fp, mn, mx, mw, dr, dl, ne, ov;
        logic te;
        push_n(4, 8'hFF, 8'h00);
        run_frame(40, n_p, fp, mn, mx, mw, dr, dl, ne, ov, te);
        n_tests++;
        if (n_p !== 4) begin n_fail++; $display("FAIL sus_pulses: got %0d, expected 4", n_p); end
        n_tests++;
        if (fp !== 2) begin n_fail++; $display("FAIL sus_first_pulse: cycle %0d, expected 2", fp); end
        n_tests++;
        if (mn !== 3 || mx !== 3 || mw !== 1) begin
            n_fail++; $display("FAIL sus_period: min=%0d max=%0d width=%0d, expected 3 3 1", mn, mx, mw);
        end
        n_tests++;
        if (dr !== DONE_REL) begin n_fail++; $display("FAIL sus_done_rise: cycle %0d, expected %0d", dr, DONE_REL); end
        n_tests++;
        if (ov !== 0) begin n_fail++; $display("FAIL sus_overlap: %0d cycles, expected 0", ov); end
        n_tests++;
        if (energy !== 30'd520200) begin n_fail++; $display("FAIL sus_energy: got %0d, expected 520200", energy); end
        n_tests++;
        if (ne !== 1) begin n_fail++; $display("FAIL sus_valid_count: got %0d, expected 1", ne); end
    endtask

    task automatic test_underrun();
        int n_p, fp, mn, mx, mw, dr, dl, ne, ov;
        logic te;
        push(8'h80, 8'h80);
        push(8'h00, 8'hFF);
        fork
            run_frame(40, n_p, fp, mn, mx, mw, dr, dl, ne, ov, te);
            begin
                repeat (12) @(posedge clk);
                push(8'h90, 8'h70);
                push(8'h10, 8'hC0);
            end
        join
        n_tests++;
        if (n_p !== 4) begin n_fail++; $display("FAIL und_pulses: got %0d, expected 4", n_p); end
        n_tests++;
        if (mn !== 3 || mx <= 3 || mw !== 1) begin
            n_fail++; $display("FAIL und_stall: min=%0d max=%0d width=%0d, expected 3 >3 1", mn, mx, mw);
        end
        n_tests++;
        if (energy !== 30'd198472) begin n_fail++; $display("FAIL und_energy: got %0d, expected 198472", energy); end
        n_tests++;
        if (ne !== 1) begin n_fail++; $display("FAIL und_valid_count: got %0d, expected 1", ne); end
    endtask

    task automatic test_fifo_full();
        logic [15:0] s [6];
        int acc;
        int n_p, fp, mn, mx, mw, dr, dl, ne, ov;
        logic te;
        s[0] = 16'h817F; s[1] = 16'h8282; s[2] = 16'hA060;
        s[3] = 16'h0000; s[4] = 16'hFFFF; s[5] = 16'hFFFF;
        acc = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1 in_valid = 1'b1; {in_real, in_imag} = s[k];
            @(negedge clk);
            if (in_ready) acc++;
        end
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (acc !== 4 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL full_accept: accepted=%0d in_ready=%b, expected 4 0", acc, in_ready);
        end
        run_frame(40, n_p, fp, mn, mx, mw, dr, dl, ne, ov, te);
        n_tests++;
        if (n_p !== 4 || energy !== 30'd138304) begin
            n_fail++; $display("FAIL full_frame: pulses=%0d energy=%0d, expected 4 138304", n_p, energy);
        end
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_drained: in_ready=%b, expected 1", in_ready); end
    endtask

    task automatic test_timeout();
        int n_p, fp, mn, mx, mw, dr, dl, ne, ov;
        logic te;
        model_block = 1'b1;
        push_n(4, 8'h80, 8'h80);
        run_frame(300, n_p, fp, mn, mx, mw, dr, dl, ne, ov, te);
        n_tests++;
        if (dl !== CMP_TIMEOUT || dr !== DONE_REL) begin
            n_fail++; $display("FAIL to_done_len: len=%0d rise=%0d, expected %0d %0d", dl, dr, CMP_TIMEOUT, DONE_REL);
        end
        n_tests++;
        if (timeout_err !== 1'b1 || ne !== 0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL to_flags: te=%b valids=%0d busy=%b, expected 1 0 0", timeout_err, ne, busy);
        end
        n_tests++;
        if (energy !== 30'd138304) begin n_fail++; $display("FAIL to_energy_held: got %0d, expected 138304", energy); end
        model_block = 1'b0;
        push_n(4, 8'h81, 8'h7F);
        run_frame(40, n_p, fp, mn, mx, mw, dr, dl, ne, ov, te);
        n_tests++;
        if (te !== 1'b0) begin n_fail++; $display("FAIL to_cleared: te=%b after start, expected 0", te); end
        n_tests++;
        if (energy !== 30'd40 || ne !== 1) begin
            n_fail++; $display("FAIL to_recover: energy=%0d valids=%0d, expected 40 1", energy, ne);
        end
    endtask

    task automatic test_reset_mid_frame();
        int n_p, fp, mn, mx, mw, dr, dl, ne, ov;
        logic te, saw_pulse;
        int ev;
        push_n(4, 8'hFF, 8'hFF);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        saw_pulse = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            if (n == 5) saw_pulse = acc_ready;
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (saw_pulse !== 1'b1 || acc_ready !== 1'b0 || acc_done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rmf_drop: pulse2=%b acc_ready=%b acc_done=%b busy=%b in_ready=%b, expected 1 0 0 0 0",
                     saw_pulse, acc_ready, acc_done, busy, in_ready);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ev = 0;
        repeat (10) begin
            @(negedge clk);
            if (energy_valid) ev++;
        end
        n_tests++;
        if (ev !== 0 || energy !== 30'd0) begin
            n_fail++; $display("FAIL rmf_quiet: valids=%0d energy=%0d, expected 0 0", ev, energy);
        end
        push_n(4, 8'h80, 8'h80);
        run_frame(40, n_p, fp, mn, mx, mw, dr, dl, ne, ov, te);
        n_tests++;
        if (n_p !== 4 || energy !== 30'd8 || ne !== 1) begin
            n_fail++; $display("FAIL rmf_new_frame: pulses=%0d energy=%0d valids=%0d, expected 4 8 1", n_p, energy, ne);
        end
    endtask

    task automatic test_start_while_busy();
        int n_p, fp, mn, mx, mw, dr, dl, ne, ov;
        logic te;
        push_n(4, 8'h90, 8'h70);
        fork
            run_frame(40, n_p, fp, mn, mx, mw, dr, dl, ne, ov, te);
            begin
                repeat (3) @(posedge clk);
                #1 start = 1'b1;
                @(posedge clk); #1 start = 1'b0;
            end
        join
        n_tests++;
        if (n_p !== 4 || ne !== 1 || energy !== 30'd8200) begin
            n_fail++; $display("FAIL busy_start: pulses=%0d valids=%0d energy=%0d, expected 4 1 8200", n_p, ne, energy);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_real = '0; in_imag = '0; start = 1'b0;
        test_reset();
        test_sustained();
        test_underrun();
        test_fifo_full();
        test_timeout();
        test_reset_mid_frame();
        test_start_while_busy();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
